// File: rtl/mult_shift_add.sv
// mult_shift_add: multi-cycle shift-and-add multiplier for MIPS MULT/MULTU.
// Latency: start accepted at edge N, done pulses in cycle N+WIDTH+1 with hi/lo valid from that edge.
// Backpressure: none queued; start is ignored while busy (RUN/FIN) and only sampled in IDLE.
//
// Build option: define SIGNED_MULT_EN to honour is_signed (MULT + MULTU). Without it every
// operation is unsigned, is_signed is ignored and the abs/negate logic is not built.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (clears FSM, datapath and hi/lo)
//   start      request, sampled only in IDLE
//   is_signed  1 = MULT (two's complement), 0 = MULTU
//   op_a/op_b  multiplicand (rs) / multiplier (rt), WIDTH bits, sampled on accept only
//   busy       high in RUN and FIN
//   done       one-cycle pulse in the cycle hi/lo take their new value
//   hi/lo      upper/lower WIDTH bits of the 2*WIDTH product

// One-bit full adder cell; the multiplier chains WIDTH of these into a ripple adder.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);
  assign o_s    = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module mult_shift_add #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic             w_neg;
  logic [WIDTH-1:0] w_addend;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH:0]   w_carry;
  logic [PW-1:0]    w_prod_shift;
  logic [PW-1:0]    w_prod;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_last   = (r_state == S_RUN) && (r_count == CW'(WIDTH - 1));

`ifdef SIGNED_MULT_EN
  logic r_neg;

  // Magnitudes are treated as unsigned, so |most-negative| = 2^(WIDTH-1) still multiplies correctly.
  assign w_mag_a = (is_signed && op_a[WIDTH-1]) ? (~op_a + WIDTH'(1)) : op_a;
  assign w_mag_b = (is_signed && op_b[WIDTH-1]) ? (~op_b + WIDTH'(1)) : op_b;
  assign w_neg   = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
  // Carry out of the negation falls off the top: arithmetic is modulo 2^PW.
  assign w_prod  = r_neg ? (~w_prod_shift + PW'(1)) : w_prod_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_neg <= 1'b0;
    end else if (w_accept) begin
      r_neg <= w_neg;
    end
  end
`else
  logic w_is_signed_unused;

  assign w_is_signed_unused = is_signed;
  assign w_mag_a = op_a;
  assign w_mag_b = op_b;
  assign w_neg   = 1'b0;
  assign w_prod  = w_prod_shift;
`endif

  // Partial-product add: acc + (mplier[0] ? mcand : 0) through the full_adder chain.
  assign w_addend   = r_mplier[0] ? r_mcand : '0;
  assign w_carry[0] = 1'b0;

  for (genvar g = 0; g < WIDTH; g++) begin : g_fa
    full_adder u_fa (
      .i_a    (r_acc[g]),
      .i_b    (w_addend[g]),
      .i_cin  (w_carry[g]),
      .o_s    (w_sum[g]),
      .o_cout (w_carry[g+1])
    );
  end

  // Carry and sum become the new accumulator; the consumed multiplier bit drops off the bottom.
  assign w_prod_shift = {w_carry[WIDTH], w_sum, r_mplier[WIDTH-1:1]};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_FIN;
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
    end else if (w_accept) begin
      r_acc    <= '0;
      r_mcand  <= w_mag_a;
      r_mplier <= w_mag_b;
      r_count  <= '0;
    end else if (r_state == S_RUN) begin
      {r_acc, r_mplier} <= w_prod_shift;
      r_count           <= r_count + CW'(1);
    end
  end

  // hi/lo are loaded on the final RUN edge from the fully shifted (and sign-fixed) product,
  // so they change in one step exactly as the FIN/done cycle begins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_last) begin
      r_hi <= w_prod[PW-1:WIDTH];
      r_lo <= w_prod[WIDTH-1:0];
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_FIN);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mult_shift_add.sv
// tb_mult_shift_add: directed checks for mult_shift_add at WIDTH=32.
// Table of operand/product records plus hand-written handshake, overlap and reset sequences.
// Expected products depend on whether SIGNED_MULT_EN is defined for the build.
module tb_mult_shift_add;
  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         is_signed;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int errors = 0;

  mult_shift_add #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sgn;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  // Launch one operation and wait (bounded) for done. lat counts negedges after the accept edge,
  // so a done in cycle N+33 gives lat=33. busy_first is busy sampled in cycle N+1.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       output logic [W-1:0] h, output logic [W-1:0] l,
                       output int lat, output logic busy_first);
    @(negedge clk);
    op_a = a; op_b = b; is_signed = s; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    busy_first = busy;
    lat = 1;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    h = hi;
    l = lo;
  endtask

  initial begin
    logic [W-1:0] h, l;
    int           lat;
    logic         bf;
    int           dones;
    int           done_lat;
    logic [W-1:0] cap_hi, cap_lo;

    vecs[0] = '{32'h0000_0003, 32'h0000_0005, 1'b0, 32'h0000_0000, 32'h0000_000F};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE};
    vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000};
    vecs[4] = '{32'h0001_0000, 32'h0001_0000, 1'b0, 32'h0000_0001, 32'h0000_0000};
    vecs[5] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 32'h3FFF_FFFF, 32'h0000_0001};
    vecs[6] = '{32'h0000_0000, 32'h1234_5678, 1'b1, 32'h0000_0000, 32'h0000_0000};
`ifdef SIGNED_MULT_EN
    vecs[7] = '{32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[8] = '{32'h0000_0007, 32'hFFFF_FFFA, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFD6};
    vecs[9] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h0000_0001};
`else
    vecs[7] = '{32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 32'h0000_0001, 32'hFFFF_FFFE};
    vecs[8] = '{32'h0000_0007, 32'hFFFF_FFFA, 1'b1, 32'h0000_0006, 32'hFFFF_FFD6};
    vecs[9] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001};
`endif

    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].sgn, h, l, lat, bf);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd33);
      chk($sformatf("vec%0d_busy_start", i), 64'(bf), 64'd1);
      chk($sformatf("vec%0d_product", i), {h, l}, {vecs[i].exp_hi, vecs[i].exp_lo});
      @(negedge clk);
      chk($sformatf("vec%0d_busy_after", i), {63'd0, busy}, 64'd0);
      chk($sformatf("vec%0d_done_after", i), {63'd0, done}, 64'd0);
      chk($sformatf("vec%0d_hold", i), {hi, lo}, {vecs[i].exp_hi, vecs[i].exp_lo});
    end

    // Restarts while busy and coincident with done must be dropped.
    @(negedge clk);
    op_a = 32'd3; op_b = 32'd5; is_signed = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    dones = 0; done_lat = 0; cap_hi = '1; cap_lo = '1;
    for (int cyc = 1; cyc <= 90; cyc++) begin
      if (done) begin
        dones++;
        if (dones == 1) begin
          done_lat = cyc;
          cap_hi = hi;
          cap_lo = lo;
        end
      end
      if (cyc == 5) begin
        op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF;
      end
      if (done) begin
        op_a = 32'h0000_0100; op_b = 32'h0000_0100;
      end
      start = (cyc == 5) || done;
      @(negedge clk);
    end
    start = 1'b0;
    chk("overlap_done_count", 64'(dones), 64'd1);
    chk("overlap_latency", 64'(done_lat), 64'd33);
    chk("overlap_product", {cap_hi, cap_lo}, 64'h0000_0000_0000_000F);
    chk("overlap_hold", {hi, lo}, 64'h0000_0000_0000_000F);
    chk("overlap_idle", {63'd0, busy}, 64'd0);

    // Reset mid-RUN aborts with no done and clears hi/lo at once.
    @(negedge clk);
    op_a = 32'd9; op_b = 32'd9; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("midrun_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("abort_no_done", 64'(dones), 64'd0);
    do_op(32'd7, 32'd6, 1'b0, h, l, lat, bf);
    chk("post_reset_latency", 64'(lat), 64'd33);
    chk("post_reset_product", {h, l}, 64'd42);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
